logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one 8-bit bitwise logic unit (XOR/AND/OR/XNOR) between two requesters.
//  Round-robin arbitration with a req/gnt/done handshake.
//  Latches the winner's operands, runs the op for EXEC_CYCLES, returns a registered result.
//  Sits between the ALU front-end requesters and the bitwise datapath.
// PARAMETERS
//  WIDTH        8   operand/result width in bits
//  EXEC_CYCLES  1   cycles spent in EXEC (legal 1..15); models datapath settle time
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  req0    in   1      requester 0 request; hold high until done0
//  op0     in   2      requester 0 opcode: 00 XOR, 01 AND, 10 OR, 11 XNOR
//  a0, b0  in   WIDTH  requester 0 operands; stable while req0 high
//  req1    in   1      requester 1 request
//  op1     in   2      requester 1 opcode
//  a1, b1  in   WIDTH  requester 1 operands
//  gnt0    out  1      requester 0 owns the unit (EXEC and DONE states)
//  gnt1    out  1      requester 1 owns the unit
//  done0   out  1      one-cycle pulse: result valid for requester 0
//  done1   out  1      one-cycle pulse: result valid for requester 1
//  result  out  WIDTH  registered op result; held until the next DONE
//  zero    out  1      result == 0; registered with result
//  busy    out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; gnt*, done*, busy, result=0; zero=1; last_served=1 (req0 wins first).
//  - FSM IDLE -> EXEC -> DONE -> IDLE. All outputs are registered.
//  - IDLE: sample req0/req1 at each edge.
//      - One request: grant it.
//      - Both: grant the requester != last_served.
//      - None: stay in IDLE.
//  - On grant (edge entering EXEC):
//      - Latch op/a/b of the winner into internal regs.
//      - Set gnt_x=1, update last_served, load cnt=EXEC_CYCLES-1.
//  - EXEC: decrement cnt each cycle. When cnt==0, at the next edge:
//      - result <= f(op, a_reg, b_reg); zero <= (f==0).
//      - done_x <= 1; state <= DONE.
//  - DONE: lasts exactly 1 cycle. done_x=1, gnt_x still 1. Next edge -> IDLE with done_x=0, gnt_x=0.
//  - Latency: EXEC_CYCLES+1 edges from the sampling edge to done high. Default is 2.
//  - Throughput: one op per EXEC_CYCLES+2 cycles.
//  - Requester rule: req must be low at the first IDLE sampling edge after done. Otherwise it is served again as a new op.
//  - req/operand changes after grant are ignored; the latched op completes.
//  - A req arriving during EXEC/DONE waits; it is considered at the next IDLE sample.
//  - Bitwise ops are width-exact; no carry or overflow. XOR is (~a&b)|(a&~b).
//  - Async reset mid-EXEC/DONE: the op is abandoned with no done pulse. All outputs return to reset values immediately.
//  - gnt0 and gnt1 are never both high. done_x implies gnt_x.
// CONFIGURATION
//  LOGIC_ARB_FIXED_PRIO_EN
//    - Defined: fixed priority; req0 always wins a simultaneous request. last_served is unused.
//    - Undefined (default): round-robin as above.
// TESTING
//  - Reset, then req0=1, op0=00, a0=8'hA5, b0=8'h0F -> gnt0 high 1 edge later, done0 2 edges later, result=8'hAA, zero=0.
//  - req0 & req1 together, op=01, a0=b0=8'hFF, a1=8'hF0, b1=8'h0F, both held high:
//      -> served 0 then 1: result=8'hFF then 8'h00 (zero=1), then 0 again.
//      -> With LOGIC_ARB_FIXED_PRIO_EN: 0,0,0 while req0 stays high.
//  - EXEC_CYCLES=4, op=11, a=8'h3C, b=8'h3C -> done 5 edges after sampling edge, result=8'hFF.
//    Change a during EXEC -> result unaffected.
//  - Assert rst_n=0 mid-EXEC -> gnt/busy drop at once, no done pulse.
//    After release, a pending req1 is served with a correct result.
//  - Random 1000 requests on both ports:
//      -> every req gets exactly one done.
//      -> result matches the golden bitwise model.
//      -> no starvation beyond one other op (round-robin).
//      -> gnt0&gnt1 never high together.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
// Request/grant/result bundle between two ALU requesters and the shared logic unit.
// The master side drives requests and operands; the slave side is the arbiter.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [1:0]       op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [1:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output req0, op0, a0, b0,
        output req1, op1, a1, b1,
        input  gnt0, gnt1, done0, done1,
        input  result, zero, busy
    );

    modport slave (
        input  req0, op0, a0, b0,
        input  req1, op1, a1, b1,
        output gnt0, gnt1, done0, done1,
        output result, zero, busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter around one bitwise logic unit (XOR/AND/OR/XNOR).
// Define LOGIC_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module logic_unit_arbiter #(
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 1
) (
    input logic           clk,
    input logic           rst_n,
    logic_unit_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done0_q;
    logic             done1_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             busy_q;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    logic             last_q;
`endif

    logic             any_req_d;
    logic             win1_d;
    logic [1:0]       op_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] xor_d;
    logic [WIDTH-1:0] result_d;

    assign any_req_d = bus.req0 | bus.req1;

    // last_q high means requester 1 was served most recently
    always_comb begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        win1_d = ~bus.req0;
`else
        win1_d = bus.req1 & (~bus.req0 | ~last_q);
`endif
    end

    assign op_d = win1_d ? bus.op1 : bus.op0;
    assign a_d  = win1_d ? bus.a1  : bus.a0;
    assign b_d  = win1_d ? bus.b1  : bus.b0;

    assign xor_d = (~a_q & b_q) | (a_q & ~b_q);

    always_comb begin
        result_d = '0;
        unique case (1'b1)
            op_q == 2'b00: result_d = xor_d;
            op_q == 2'b01: result_d = a_q & b_q;
            op_q == 2'b10: result_d = a_q | b_q;
            op_q == 2'b11: result_d = ~xor_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        state_q <= EXEC;
                        cnt_q   <= CNT_INIT;
                        op_q    <= op_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        gnt0_q  <= ~win1_d;
                        gnt1_q  <= win1_d;
                        busy_q  <= 1'b1;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
                        last_q  <= win1_d;
`endif
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= DONE;
                        result_q <= result_d;
                        zero_q   <= (result_d == '0);
                        done0_q  <= gnt0_q;
                        done1_q  <= gnt1_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: one instance at EXEC_CYCLES=1, one at 4.
// Inputs driven and outputs sampled on the falling edge.
module tb_logic_unit_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(8)) b1 ();
    logic_unit_arbiter_if #(.WIDTH(8)) b4 ();

    logic_unit_arbiter #(.WIDTH(8), .EXEC_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    logic_unit_arbiter #(.WIDTH(8), .EXEC_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] golden(input logic [1:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            2'd0:    return a ^ b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic wait_done(input bit sel, output int who,
                             output logic [7:0] res, output logic z);
        bit seen;
        logic g0, g1, d0, d1;
        seen = 0;
        who  = -1;
        res  = '0;
        z    = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            g0 = sel ? b4.gnt0  : b1.gnt0;
            g1 = sel ? b4.gnt1  : b1.gnt1;
            d0 = sel ? b4.done0 : b1.done0;
            d1 = sel ? b4.done1 : b1.done1;
            chk("gnt_excl", 32'(g0 & g1), 32'd0);
            if (d0 | d1) begin
                chk("done_has_gnt", 32'((d0 & g0) | (d1 & g1)), 32'd1);
                seen = 1;
                who  = d1 ? 1 : 0;
                res  = sel ? b4.result : b1.result;
                z    = sel ? b4.zero   : b1.zero;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int         who;
        logic [7:0] res;
        logic       z;
        int         exp_who [3];
        logic [7:0] exp_res [3];

        b1.req0 = 0; b1.op0 = 0; b1.a0 = 0; b1.b0 = 0;
        b1.req1 = 0; b1.op1 = 0; b1.a1 = 0; b1.b1 = 0;
        b4.req0 = 0; b4.op0 = 0; b4.a0 = 0; b4.b0 = 0;
        b4.req1 = 0; b4.op1 = 0; b4.a1 = 0; b4.b1 = 0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt0", 32'(b1.gnt0), 32'd0);
        chk("rst_gnt1", 32'(b1.gnt1), 32'd0);
        chk("rst_done0", 32'(b1.done0), 32'd0);
        chk("rst_done1", 32'(b1.done1), 32'd0);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_result", 32'(b1.result), 32'd0);
        chk("rst_zero", 32'(b1.zero), 32'd1);

        // single XOR from requester 0
        rst_n = 1'b1;
        b1.req0 = 1; b1.op0 = 2'b00; b1.a0 = 8'hA5; b1.b0 = 8'h0F;
        @(negedge clk);
        chk("x_gnt0", 32'(b1.gnt0), 32'd1);
        chk("x_gnt1", 32'(b1.gnt1), 32'd0);
        chk("x_busy", 32'(b1.busy), 32'd1);
        chk("x_done0_early", 32'(b1.done0), 32'd0);
        b1.req0 = 0;
        @(negedge clk);
        chk("x_done0", 32'(b1.done0), 32'd1);
        chk("x_gnt0_done", 32'(b1.gnt0), 32'd1);
        chk("x_result", 32'(b1.result), 32'hAA);
        chk("x_zero", 32'(b1.zero), 32'd0);
        @(negedge clk);
        chk("x_done0_drop", 32'(b1.done0), 32'd0);
        chk("x_gnt0_drop", 32'(b1.gnt0), 32'd0);
        chk("x_busy_drop", 32'(b1.busy), 32'd0);
        chk("x_result_held", 32'(b1.result), 32'hAA);

        // simultaneous held requests, fresh from reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b1.op0 = 2'b01; b1.a0 = 8'hFF; b1.b0 = 8'hFF;
        b1.op1 = 2'b01; b1.a1 = 8'hF0; b1.b1 = 8'h0F;
        b1.req0 = 1; b1.req1 = 1;
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        exp_who = '{0, 0, 0};
        exp_res = '{8'hFF, 8'hFF, 8'hFF};
`else
        exp_who = '{0, 1, 0};
        exp_res = '{8'hFF, 8'h00, 8'hFF};
`endif
        for (int k = 0; k < 3; k++) begin
            wait_done(1'b0, who, res, z);
            chk($sformatf("rr_who%0d", k), 32'(who), 32'(exp_who[k]));
            chk($sformatf("rr_res%0d", k), 32'(res), 32'(exp_res[k]));
            chk($sformatf("rr_zero%0d", k), 32'(z),
                32'(exp_res[k] == 8'h00));
        end
        b1.req0 = 0; b1.req1 = 0;
        repeat (3) @(negedge clk);
        chk("rr_idle", 32'(b1.busy), 32'd0);

        // EXEC_CYCLES=4, XNOR, operand change during EXEC ignored
        b4.req0 = 1; b4.op0 = 2'b11; b4.a0 = 8'h3C; b4.b0 = 8'h3C;
        @(negedge clk);
        chk("e4_gnt0", 32'(b4.gnt0), 32'd1);
        chk("e4_done_e1", 32'(b4.done0), 32'd0);
        b4.req0 = 0;
        @(negedge clk);
        chk("e4_done_e2", 32'(b4.done0), 32'd0);
        b4.a0 = 8'h00;
        @(negedge clk);
        chk("e4_done_e3", 32'(b4.done0), 32'd0);
        @(negedge clk);
        chk("e4_done_e4", 32'(b4.done0), 32'd0);
        chk("e4_busy_e4", 32'(b4.busy), 32'd1);
        @(negedge clk);
        chk("e4_done_e5", 32'(b4.done0), 32'd1);
        chk("e4_result", 32'(b4.result), 32'hFF);
        chk("e4_zero", 32'(b4.zero), 32'd0);

        // async reset mid-EXEC, then pending req1 is served
        b4.req1 = 1; b4.op1 = 2'b10; b4.a1 = 8'h30; b4.b1 = 8'h03;
        @(negedge clk);
        chk("ar_idle", 32'(b4.busy), 32'd0);
        @(negedge clk);
        chk("ar_gnt1", 32'(b4.gnt1), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_gnt1_drop", 32'(b4.gnt1), 32'd0);
        chk("ar_busy_drop", 32'(b4.busy), 32'd0);
        chk("ar_done1", 32'(b4.done1), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_no_done", 32'(b4.done1), 32'd0);
        end
        rst_n = 1'b1;
        wait_done(1'b1, who, res, z);
        chk("ar_who", 32'(who), 32'd1);
        chk("ar_result", 32'(res), 32'h33);
        chk("ar_zero", 32'(z), 32'd0);
        b4.req1 = 0;
        @(negedge clk);

        // random single requests against the golden model
        for (int k = 0; k < 40; k++) begin
            int         sel;
            logic [1:0] op;
            logic [7:0] a, b;
            sel = int'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            if (sel == 0) begin
                b1.req0 = 1; b1.op0 = op; b1.a0 = a; b1.b0 = b;
            end else begin
                b1.req1 = 1; b1.op1 = op; b1.a1 = a; b1.b1 = b;
            end
            wait_done(1'b0, who, res, z);
            b1.req0 = 0; b1.req1 = 0;
            chk("rnd_who", 32'(who), 32'(sel));
            chk("rnd_result", 32'(res), 32'(golden(op, a, b)));
            chk("rnd_zero", 32'(z), 32'(golden(op, a, b) == 8'h00));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
